// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: a round-robin grant feeds one operation at a time
// through an IDLE -> EXEC -> RESP sequence, and the result is held until the consumer takes it.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 4,
    parameter int MUL_LAT    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [DATA_WIDTH-1:0] i_req0_data_a,
    input  logic [DATA_WIDTH-1:0] i_req0_data_b,
    input  logic [INST_WIDTH-1:0] i_req0_inst,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [DATA_WIDTH-1:0] i_req1_data_a,
    input  logic [DATA_WIDTH-1:0] i_req1_data_b,
    input  logic [INST_WIDTH-1:0] i_req1_inst,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_id,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_overflow,
    output logic                  o_rsp_err,
    output logic                  o_busy
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [INST_WIDTH-1:0] OP_SADD = INST_WIDTH'(0);
    localparam logic [INST_WIDTH-1:0] OP_SSUB = INST_WIDTH'(1);
    localparam logic [INST_WIDTH-1:0] OP_SMUL = INST_WIDTH'(2);
    localparam logic [INST_WIDTH-1:0] OP_SMAX = INST_WIDTH'(3);
    localparam logic [INST_WIDTH-1:0] OP_SMIN = INST_WIDTH'(4);
    localparam logic [INST_WIDTH-1:0] OP_UADD = INST_WIDTH'(5);
    localparam logic [INST_WIDTH-1:0] OP_USUB = INST_WIDTH'(6);
    localparam logic [INST_WIDTH-1:0] OP_UMUL = INST_WIDTH'(7);
    localparam logic [INST_WIDTH-1:0] OP_UMAX = INST_WIDTH'(8);
    localparam logic [INST_WIDTH-1:0] OP_UMIN = INST_WIDTH'(9);
    localparam logic [INST_WIDTH-1:0] OP_AND  = INST_WIDTH'(10);
    localparam logic [INST_WIDTH-1:0] OP_OR   = INST_WIDTH'(11);
    localparam logic [INST_WIDTH-1:0] OP_XOR  = INST_WIDTH'(12);
    localparam logic [INST_WIDTH-1:0] OP_NOT  = INST_WIDTH'(13);
    localparam logic [INST_WIDTH-1:0] OP_REV  = INST_WIDTH'(14);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  id_q, id_d;
    logic [W-1:0]          rsp_data_q, rsp_data_d;
    logic                  rsp_ovf_q, rsp_ovf_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_id_q, rsp_id_d;

    logic                  grant_id;
    logic [INST_WIDTH-1:0] inst_sel;
    logic [W:0]            uadd_full;
    logic [W-1:0]          diff;
    logic [2*W-1:0]        smul_full, umul_full;
    logic [W-1:0]          rev;
    logic [W-1:0]          alu_data;
    logic                  alu_ovf, alu_err;

    // Contention goes to the pointer; a lone requester always wins.
    assign grant_id = (i_req0_valid && i_req1_valid) ? ptr_q : i_req1_valid;
    assign inst_sel = grant_id ? i_req1_inst : i_req0_inst;

    assign o_req0_ready = (state_q == IDLE) && !i_rst && i_req0_valid && !grant_id;
    assign o_req1_ready = (state_q == IDLE) && !i_rst && i_req1_valid && grant_id;

    assign uadd_full = {1'b0, a_q} + {1'b0, b_q};
    assign diff      = a_q - b_q;
    // Sign-extending to 2W makes the unsigned 2W product equal the signed one modulo 2^2W.
    assign smul_full = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    assign umul_full = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

    always_comb begin
        for (int i = 0; i < W; i++) begin
            rev[i] = a_q[W-1-i];
        end
    end

    always_comb begin
        alu_data = '0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (inst_q)
            OP_SADD: begin
                alu_data = uadd_full[W-1:0];
                alu_ovf  = (a_q[W-1] == b_q[W-1]) && (uadd_full[W-1] != a_q[W-1]);
            end
            OP_SSUB: begin
                alu_data = diff;
                alu_ovf  = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
            end
            OP_SMUL: begin
                alu_data = smul_full[W-1:0];
                alu_ovf  = smul_full[2*W-1:W] != {W{smul_full[W-1]}};
            end
            OP_SMAX: alu_data = ($signed(a_q) > $signed(b_q)) ? a_q : b_q;
            OP_SMIN: alu_data = ($signed(a_q) < $signed(b_q)) ? a_q : b_q;
            OP_UADD: begin
                alu_data = uadd_full[W-1:0];
                alu_ovf  = uadd_full[W];
            end
            OP_USUB: begin
                alu_data = diff;
                alu_ovf  = a_q < b_q;
            end
            OP_UMUL: begin
                alu_data = umul_full[W-1:0];
                alu_ovf  = |umul_full[2*W-1:W];
            end
            OP_UMAX: alu_data = (a_q > b_q) ? a_q : b_q;
            OP_UMIN: alu_data = (a_q < b_q) ? a_q : b_q;
            OP_AND:  alu_data = a_q & b_q;
            OP_OR:   alu_data = a_q | b_q;
            OP_XOR:  alu_data = a_q ^ b_q;
            OP_NOT:  alu_data = ~a_q;
            OP_REV:  alu_data = rev;
            default: alu_err  = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        inst_d     = inst_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_err_d  = rsp_err_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    state_d = EXEC;
                    ptr_d   = ~grant_id;
                    id_d    = grant_id;
                    a_d     = grant_id ? i_req1_data_a : i_req0_data_a;
                    b_d     = grant_id ? i_req1_data_b : i_req0_data_b;
                    inst_d  = inst_sel;
                    cnt_d   = (inst_sel == OP_SMUL || inst_sel == OP_UMUL) ?
                              CNT_W'(MUL_LAT - 1) : '0;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    rsp_data_d = alu_data;
                    rsp_ovf_d  = alu_ovf;
                    rsp_err_d  = alu_err;
                    rsp_id_d   = id_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            inst_q     <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            inst_q     <= inst_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_err_q  <= rsp_err_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign o_rsp_valid    = (state_q == RESP);
    assign o_busy         = (state_q != IDLE);
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_overflow = rsp_ovf_q;
    assign o_rsp_err      = rsp_err_q;
    assign o_rsp_id       = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random stimulus for alu_arbiter; every accepted operation is pushed to a
// scoreboard with its expected result and arrival cycle, then matched against the response.
module tb_alu_arbiter;

    localparam int MUL_LAT = 4;

    logic        i_clk;
    logic        i_rst;
    logic        i_req0_valid, i_req1_valid;
    logic        o_req0_ready, o_req1_ready;
    logic [31:0] i_req0_data_a, i_req0_data_b, i_req1_data_a, i_req1_data_b;
    logic [3:0]  i_req0_inst, i_req1_inst;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_id;
    logic [31:0] o_rsp_data;
    logic        o_rsp_overflow, o_rsp_err, o_busy;

    alu_arbiter #(.DATA_WIDTH(32), .INST_WIDTH(4), .MUL_LAT(MUL_LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_data_a(i_req0_data_a), .i_req0_data_b(i_req0_data_b), .i_req0_inst(i_req0_inst),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_data_a(i_req1_data_a), .i_req1_data_b(i_req1_data_b), .i_req1_inst(i_req1_inst),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
        .o_rsp_data(o_rsp_data), .o_rsp_overflow(o_rsp_overflow), .o_rsp_err(o_rsp_err),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        ovf;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          shown = 0;
    logic        lastReady0, lastReady1, lastHs, lastHsId;
    logic [31:0] lastRspData;
    logic        lastRspOvf, lastRspErr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model computed with 64-bit arithmetic rather than flag logic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic ov, output logic er);
        longint      sa, sb2, r;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        d   = '0;
        ov  = 1'b0;
        er  = 1'b0;
        r   = 0;
        u   = '0;
        case (op)
            4'd0: begin r = sa + sb2; d = r[31:0]; ov = (r != longint'($signed(r[31:0]))); end
            4'd1: begin r = sa - sb2; d = r[31:0]; ov = (r != longint'($signed(r[31:0]))); end
            4'd2: begin r = sa * sb2; d = r[31:0]; ov = (r != longint'($signed(r[31:0]))); end
            4'd3: d = (sa >= sb2) ? a : b;
            4'd4: d = (sa <= sb2) ? a : b;
            4'd5: begin u = {32'b0, a} + {32'b0, b}; d = u[31:0]; ov = u[32]; end
            4'd6: begin d = a - b; ov = (a < b); end
            4'd7: begin u = {32'b0, a} * {32'b0, b}; d = u[31:0]; ov = (u[63:32] != 32'b0); end
            4'd8: d = (a >= b) ? a : b;
            4'd9: d = (a <= b) ? a : b;
            4'd10: d = a & b;
            4'd11: d = a | b;
            4'd12: d = a ^ b;
            4'd13: d = ~a;
            4'd14: for (int i = 0; i < 32; i++) d[i] = a[31-i];
            default: er = 1'b1;
        endcase
    endfunction

    // Samples one cycle 1ns after the falling edge, then advances to the next falling edge.
    task automatic applyStimulus();
        exp_t e;
        #1;
        lastReady0 = o_req0_ready;
        lastReady1 = o_req1_ready;
        lastHs     = 1'b0;
        if (i_rst) begin
            check("rst_ready0", o_req0_ready, 0);
            check("rst_ready1", o_req1_ready, 0);
        end
        if (i_req0_valid && i_req1_valid)
            check("one_ready", o_req0_ready & o_req1_ready, 0);
        if ((o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid)) begin
            lastHs   = 1'b1;
            lastHsId = o_req1_ready;
            e.id     = o_req1_ready;
            if (o_req1_ready) begin
                model(i_req1_inst, i_req1_data_a, i_req1_data_b, e.data, e.ovf, e.err);
                e.due = cyc + ((i_req1_inst == 4'd2 || i_req1_inst == 4'd7) ? 1 + MUL_LAT : 2);
            end else begin
                model(i_req0_inst, i_req0_data_a, i_req0_data_b, e.data, e.ovf, e.err);
                e.due = cyc + ((i_req0_inst == 4'd2 || i_req0_inst == 4'd7) ? 1 + MUL_LAT : 2);
            end
            sb.push_back(e);
        end
        if (o_rsp_valid) begin
            check("rsp_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                check("rsp_id", o_rsp_id, sb[0].id);
                check("rsp_data", o_rsp_data, sb[0].data);
                check("rsp_ovf", o_rsp_overflow, sb[0].ovf);
                check("rsp_err", o_rsp_err, sb[0].err);
                if (!shown) check("rsp_latency", cyc, sb[0].due);
                shown = 1;
                if (i_rsp_ready) begin
                    lastRspData = o_rsp_data;
                    lastRspOvf  = o_rsp_overflow;
                    lastRspErr  = o_rsp_err;
                    void'(sb.pop_front());
                    shown = 0;
                end
            end
        end else if (sb.size() > 0) begin
            check("rsp_late", cyc > sb[0].due, 0);
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && sb.size() > 0; k++) applyStimulus();
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic runOp(input bit port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            i_req1_valid = 1; i_req1_inst = op; i_req1_data_a = a; i_req1_data_b = b;
        end else begin
            i_req0_valid = 1; i_req0_inst = op; i_req0_data_a = a; i_req0_data_b = b;
        end
        applyStimulus();
        check("runop_grant", lastHs, 1);
        check("runop_grant_id", lastHsId, port);
        i_req0_valid = 0;
        i_req1_valid = 0;
        drain();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] d, input logic ov, input logic er);
        check({tag, "_data"}, lastRspData, d);
        check({tag, "_ovf"}, lastRspOvf, ov);
        check({tag, "_err"}, lastRspErr, er);
    endtask

    initial begin
        logic got;
        i_rst = 1; i_rsp_ready = 1;
        i_req0_valid = 0; i_req1_valid = 0;
        i_req0_data_a = '0; i_req0_data_b = '0; i_req0_inst = '0;
        i_req1_data_a = '0; i_req1_data_b = '0; i_req1_inst = '0;
        @(negedge i_clk);
        i_req0_valid = 1; i_req1_valid = 1;
        applyStimulus();
        applyStimulus();
        check("rst_valid", o_rsp_valid, 0);
        check("rst_data", o_rsp_data, 0);
        check("rst_ovf", o_rsp_overflow, 0);
        check("rst_err", o_rsp_err, 0);
        check("rst_id", o_rsp_id, 0);
        check("rst_busy", o_busy, 0);
        i_rst = 0; i_req0_valid = 0; i_req1_valid = 0;
        applyStimulus();

        // Signed add overflow with two-cycle latency.
        i_req0_valid = 1; i_req0_inst = 4'd0; i_req0_data_a = 32'h7FFF_FFFF; i_req0_data_b = 32'h1;
        applyStimulus();
        check("add_ready0", lastReady0, 1);
        i_req0_valid = 0;
        applyStimulus();
        check("add_valid", o_rsp_valid, 1);
        check("add_data", o_rsp_data, 32'h8000_0000);
        check("add_ovf", o_rsp_overflow, 1);
        check("add_id", o_rsp_id, 0);
        drain();

        // Round-robin with both requesters held from reset.
        i_rst = 1;
        applyStimulus();
        i_rst = 0;
        i_req0_valid = 1; i_req0_inst = 4'd5; i_req0_data_a = 32'h1; i_req0_data_b = 32'h2;
        i_req1_valid = 1; i_req1_inst = 4'd5; i_req1_data_a = 32'hFFFF_FFFF; i_req1_data_b = 32'h1;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int k = 0; k < 8 && !got; k++) begin
                applyStimulus();
                got = lastHs;
            end
            check("rr_grant_seen", got, 1);
            check("rr_grant_id", lastHsId, g % 2);
        end
        i_req0_valid = 0; i_req1_valid = 0;
        drain();
        checkOutput("rr_last", 32'h0, 1'b1, 1'b0);

        // Unsigned multiply on requester 1: busy through EXEC and RESP.
        i_req1_valid = 1; i_req1_inst = 4'd7; i_req1_data_a = 32'h1_0000; i_req1_data_b = 32'h1_0000;
        applyStimulus();
        check("mul_grant_id", lastHsId, 1);
        i_req1_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            check("mul_busy", o_busy, 1);
            check("mul_valid", o_rsp_valid, k == 5);
            applyStimulus();
        end
        check("mul_idle", o_busy, 0);
        checkOutput("mul", 32'h0, 1'b1, 1'b0);

        runOp(0, 4'd14, 32'h0000_0001, 32'h0);
        checkOutput("rev", 32'h8000_0000, 1'b0, 1'b0);
        runOp(1, 4'd15, 32'h1234_5678, 32'h9);
        checkOutput("illegal", 32'h0, 1'b0, 1'b1);
        runOp(0, 4'd3, 32'hFFFF_FFFF, 32'h1);
        checkOutput("smax", 32'h1, 1'b0, 1'b0);
        runOp(1, 4'd8, 32'hFFFF_FFFF, 32'h1);
        checkOutput("umax", 32'hFFFF_FFFF, 1'b0, 1'b0);
        runOp(0, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("smul_ovf", 32'h8000_0000, 1'b1, 1'b0);
        runOp(1, 4'd1, 32'h8000_0000, 32'h1);
        checkOutput("ssub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b0);
        runOp(0, 4'd6, 32'h1, 32'h2);
        checkOutput("usub_borrow", 32'hFFFF_FFFF, 1'b1, 1'b0);
        runOp(1, 4'd4, 32'h5, 32'h5);
        checkOutput("smin_tie", 32'h5, 1'b0, 1'b0);

        // Response stalled for three cycles while both requesters knock.
        i_rsp_ready = 0;
        i_req1_valid = 1; i_req1_inst = 4'd12; i_req1_data_a = 32'hF0F0_1234; i_req1_data_b = 32'h0FF0_4321;
        applyStimulus();
        check("stall_grant_id", lastHsId, 1);
        i_req1_valid = 0;
        applyStimulus();
        i_req0_valid = 1; i_req1_valid = 1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            check("stall_valid", o_rsp_valid, 1);
            check("stall_data", o_rsp_data, 32'hFF00_5115);
            check("stall_ready0", lastReady0, 0);
            check("stall_ready1", lastReady1, 0);
        end
        i_rsp_ready = 1; i_req0_valid = 0; i_req1_valid = 0;
        applyStimulus();
        check("stall_idle", o_busy, 0);

        // Reset during multiply EXEC discards the operation.
        i_req0_valid = 1; i_req0_inst = 4'd2; i_req0_data_a = 32'h3; i_req0_data_b = 32'h5;
        applyStimulus();
        check("rstmul_grant", lastHs, 1);
        i_req0_valid = 0;
        applyStimulus();
        applyStimulus();
        i_rst = 1;
        applyStimulus();
        sb.delete();
        shown = 0;
        i_rst = 0;
        check("rstmul_valid", o_rsp_valid, 0);
        check("rstmul_data", o_rsp_data, 0);
        check("rstmul_ovf", o_rsp_overflow, 0);
        check("rstmul_err", o_rsp_err, 0);
        check("rstmul_id", o_rsp_id, 0);
        check("rstmul_busy", o_busy, 0);
        runOp(0, 4'd0, 32'h5, 32'h6);
        checkOutput("post_rst", 32'hB, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            runOp(i[0], 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        applyStimulus();
        check("final_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter INST_WIDTH, default 4, opcode width.
REQ-003 SHALL have parameter MUL_LAT, default 4 (min 1), execute cycles for opcodes 2 and 7.
REQ-004 SHALL have port i_clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_req0_valid / i_req1_valid  input  1  requester k presents an operation.
REQ-007 SHALL have ports o_req0_ready / o_req1_ready  output  1  operation of requester k accepted this cycle.
REQ-008 SHALL have ports i_reqK_data_a, i_reqK_data_b  input  DATA_WIDTH  operands, K in {0,1}.
REQ-009 SHALL have ports i_reqK_inst  input  INST_WIDTH  opcode, K in {0,1}.
REQ-010 SHALL have port o_rsp_valid  output  1  result available.
REQ-011 SHALL have port i_rsp_ready  input  1  consumer takes result.
REQ-012 SHALL have port o_rsp_id  output  1  index of requester owning the result.
REQ-013 SHALL have ports o_rsp_data  output  DATA_WIDTH, o_rsp_overflow  output  1, o_rsp_err  output  1  result, overflow, illegal-opcode flag.
REQ-014 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-016 In IDLE with any valid, SHALL grant exactly one requester, assert its ready combinationally that cycle, register operands/opcode/id, go to EXEC.
REQ-017 Ready SHALL be low for both requesters outside IDLE and for the non-granted requester.
REQ-018 Arbitration SHALL be round-robin: both valid -> pointer requester wins; single valid -> that requester wins; after any grant pointer = other requester.
REQ-019 EXEC SHALL last 1 cycle, or MUL_LAT cycles for opcodes 2/7 (down-counter); result, overflow, err registered on last EXEC cycle; then RESP.
REQ-020 Latency: handshake in cycle T -> o_rsp_valid first high in T+2 (non-mul) or T+1+MUL_LAT (mul).
REQ-021 In RESP, o_rsp_valid SHALL be high and o_rsp_* stable until i_rsp_ready high; that cycle -> IDLE; next accept no earlier than following cycle.
REQ-022 Opcodes: 0 signed add, 1 signed sub (a-b), 2 signed mul low word, 3 signed max, 4 signed min, 5 unsigned add, 6 unsigned sub, 7 unsigned mul low word, 8 unsigned max, 9 unsigned min, 10 AND, 11 OR, 12 XOR, 13 NOT a, 14 bit-reverse a (bit i -> bit DATA_WIDTH-1-i).
REQ-023 Opcode 15 SHALL give o_rsp_data 0, o_rsp_overflow 0, o_rsp_err 1; all others err 0.
REQ-024 Overflow: signed add/sub = result not representable in signed DATA_WIDTH; signed mul = full 2*DATA_WIDTH product not sign-extension of low word; unsigned add = carry out; unsigned sub = a<b; unsigned mul = upper word nonzero; all other opcodes 0.
REQ-025 Max/min with equal operands SHALL return that value; ties irrelevant to id.
REQ-026 o_rsp_data, o_rsp_overflow, o_rsp_err, o_rsp_id SHALL be registered and outside RESP hold the last value (0 after reset).
REQ-027 Requester inputs changing while not granted SHALL have no effect; captured operands SHALL not change during EXEC/RESP.

Reset
REQ-028 i_rst high at a clock edge SHALL force IDLE, pointer 0, counter 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_overflow 0, o_rsp_err 0, o_rsp_id 0, o_busy 0, regardless of state.
REQ-029 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response emitted for it.
REQ-030 While i_rst high both ready outputs SHALL be 0.

Verification
REQ-031 Req0 valid, inst 0, a=0x7FFFFFFF, b=1, i_rsp_ready=1 -> ready0 in T, rsp T+2: data 0x80000000, overflow 1, id 0.
REQ-032 Both valid from reset, opcode 5 each, held -> grants 0,1,0,1 alternating; req1 a=0xFFFFFFFF b=1 -> data 0, overflow 1, id 1.
REQ-033 Req1 inst 7, a=0x10000, b=0x10000, MUL_LAT=4 -> rsp valid T+5, data 0, overflow 1; o_busy high T+1..T+5.
REQ-034 Inst 14, a=0x00000001 -> data 0x80000000; inst 15 -> data 0, err 1; inst 3 a=0xFFFFFFFF b=1 -> 1; inst 8 same -> 0xFFFFFFFF.
REQ-035 Response with i_rsp_ready low 3 cycles -> valid and data held stable, both readies 0; ready high -> IDLE next cycle.
REQ-036 i_rst pulsed during mul EXEC -> next cycle all outputs 0, no response; new req0 accepted immediately after reset release.
